game_clock_score_ctrl: RTL and testbench
========================================

// Module: game_clock_score_ctrl
// PURPOSE
//  Parametrised game-clock and multi-team score controller for the scoreboard top level.
//  - Runs a multi-period MM:SS countdown with a run/pause FSM.
//  - Keeps saturating scores for NUM_TEAMS teams.
//  - Drives an 8-digit multiplexed seven-segment display:
//    MM SS on digits 0-3, team1 on digits 4-5, team0 on digits 6-7.
//  - Button pulses arrive already debounced and one cycle wide from the input-conditioning stage.
// PARAMETERS
//  CLK_HZ       100_000_000  clock cycles per game second
//  PERIOD_MIN   12           period length in minutes (1..99)
//  NUM_PERIODS  4            periods per game (1..15)
//  NUM_TEAMS    2            score channels (2..8)
//  SCORE_MAX    99           score saturation ceiling (<=99)
//  SCAN_BITS    17           log2 of cycles per display digit
// PORTS
//  clock         in   1              system clock
//  reset         in   1              synchronous, active-high; clears everything
//  start_pause   in   1              pulse: start / pause / resume / next period
//  reset_clock   in   1              pulse: reload PERIOD_MIN:00, period=1, state IDLE
//  reset_points  in   1              pulse: all scores to 0
//  team_sel      in   3              team index receiving award; values >=NUM_TEAMS ignored
//  pt1/pt2/pt3   in   1              pulses: add 1/2/3 points to team_sel
//  pt_undo       in   1              pulse: subtract 1 from team_sel, floor 0
//  minutes       out  7              remaining minutes
//  seconds       out  6              remaining seconds
//  period        out  4              current period, 1-based
//  running       out  1              high in RUN
//  horn          out  1              one-cycle pulse at period expiry
//  game_over     out  1              high in FINAL
//  scores        out  7*NUM_TEAMS    flat bus; team i at [7*i +: 7]
//  anode         out  8              active-low digit enables
//  seg           out  7              active-low cathodes {a..g}
// BEHAVIOUR
//  Reset values:
//   - state IDLE, minutes=PERIOD_MIN, seconds=0, period=1.
//   - scores all 0; running=horn=game_over=0.
//   - scan counter 0; anode=8'hFE.
//  FSM: IDLE -start-> RUN; RUN -start-> PAUSE; PAUSE -start-> RUN;
//   - RUN reaching 00:00 -> BREAK (horn pulse in the same cycle as the 00:00 load).
//   - BREAK -start-> RUN with PERIOD_MIN:00 loaded, period+1, if period<NUM_PERIODS.
//   - Expiry of the last period -> FINAL; only reset or reset_clock leave FINAL.
//  Tick counter:
//   - Counts 0..CLK_HZ-1 only in RUN; wrap emits a 1-cycle tick.
//   - Frozen (not cleared) in PAUSE, so a paused partial second is kept.
//   - Cleared on start from IDLE/BREAK and on reset_clock.
//  Countdown on tick:
//   - seconds>0: seconds-1.
//   - else minutes-1 and seconds=59.
//   - 00:01 -> 00:00 is the expiry event; no underflow is possible.
//  reset_clock outranks start_pause in the same cycle.
//  Scores:
//   - Updated in every state, including FINAL.
//   - Simultaneous pulses: reset_points > pt3 > pt2 > pt1 > pt_undo; one update per cycle.
//   - Add saturates at SCORE_MAX (e.g. 98+3=99); undo saturates at 0.
//   - Result visible on scores the cycle after the pulse.
//  Display:
//   - scan = counter[SCAN_BITS+2:SCAN_BITS]; digit k active when anode[k]=0.
//   - BCD split by /10, %10 on 7-bit values.
//   - Undefined code shows blank (7'h7F), never a stale digit.
//  All outputs registered except seg, which is decoded from the registered digit.
// STRUCTURE
//  Shared package/include (sb_pkg):
//   - FSM state encodings IDLE/RUN/PAUSE/BREAK/FINAL.
//   - Seven-segment glyph table, SCORE_W=7.
//  Sub-module seg_scan8: scan counter, digit mux, BCD split, glyph decode.
//   - Inputs: 8 BCD nibbles. Outputs: anode, seg.
//  Top holds the FSM, tick divider, countdown and score channels (generate loop).
// TESTING (sim with CLK_HZ=10, PERIOD_MIN=1, NUM_PERIODS=2, SCAN_BITS=2)
//  1. reset; start; 600 cycles -> 00:00, horn for exactly 1 cycle, state BREAK, period=1.
//  2. start in BREAK -> 01:00, period=2; run to expiry -> game_over=1; start ignored.
//  3. RUN 15 cycles, pause 50 cycles, resume -> next tick 5 cycles later, 00:58 at cycle 20.
//  4. team0 at 97, pt3 -> 99; pt1 -> 99; pt_undo x100 -> 0, never wraps.
//  5. pt1+pt3 same cycle on team1 -> +3 only; team_sel=5 with NUM_TEAMS=2 -> no change.
//  6. reset mid-RUN at 00:37 -> next cycle 01:00, IDLE, scores 0, anode=8'hFE.
//  7. scores 42/7, time 01:00 -> anode sweeps FE..7F; digit 7 "2", digit 6 "4", digit 5 "7".

Source files
------------

// File: rtl/sb_pkg.sv
// Shared scoreboard types: FSM encoding, score width, BCD split and seven-segment glyphs.
// Also holds the saturating score arithmetic used by every team channel.
package sb_pkg;

    localparam int SCORE_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_BREAK = 3'd3,
        ST_FINAL = 3'd4
    } state_t;

    // Any nibble above 9 decodes to an unlit digit.
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    // Active-low cathodes ordered {a,b,c,d,e,f,g}.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h01;
            4'd1:    g = 7'h4F;
            4'd2:    g = 7'h12;
            4'd3:    g = 7'h06;
            4'd4:    g = 7'h4C;
            4'd5:    g = 7'h24;
            4'd6:    g = 7'h20;
            4'd7:    g = 7'h0F;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h04;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] v,
                                                   input logic [1:0]         inc,
                                                   input logic [SCORE_W-1:0] ceil);
        logic [SCORE_W:0] s;
        s = {1'b0, v} + {{(SCORE_W-1){1'b0}}, inc};
        return (s > {1'b0, ceil}) ? ceil : s[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] v);
        return (v == '0) ? '0 : v - SCORE_W'(1);
    endfunction

endpackage

// File: rtl/seg_scan8.sv
// Eight-digit multiplexed seven-segment driver: free-running scan counter, digit mux
// and glyph decode. Anode and digit are registered; seg is decoded from the held digit.
module seg_scan8
    import sb_pkg::*;
#(
    parameter int SCAN_BITS = 17
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] digits,
    output logic [7:0]  anode,
    output logic [6:0]  seg
);

    localparam int CNT_W = SCAN_BITS + 3;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] scan_cnt;
    logic [CNT_W-1:0] scan_nxt;
    logic [2:0]       scan_idx;
    logic [3:0]       digit;

    assign scan_nxt = scan_cnt + CNT_ONE;
    assign scan_idx = scan_nxt[CNT_W-1:SCAN_BITS];

    // Anode and digit track the counter value being loaded, so they always agree.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt <= '0;
            anode    <= 8'hFE;
            digit    <= BLANK_CODE;
        end else begin
            scan_cnt <= scan_nxt;
            anode    <= ~(8'b1 << scan_idx);
            digit    <= digits[4*scan_idx +: 4];
        end
    end

    assign seg = glyph(digit);

endmodule

// File: rtl/game_clock_score_ctrl.sv
// Game clock and multi-team score controller: run/pause FSM, MM:SS period countdown,
// saturating team scores and the eight-digit scoreboard display.
module game_clock_score_ctrl
    import sb_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int PERIOD_MIN  = 12,
    parameter int NUM_PERIODS = 4,
    parameter int NUM_TEAMS   = 2,
    parameter int SCORE_MAX   = 99,
    parameter int SCAN_BITS   = 17
)(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start_pause,
    input  logic                         reset_clock,
    input  logic                         reset_points,
    input  logic [2:0]                   team_sel,
    input  logic                         pt1,
    input  logic                         pt2,
    input  logic                         pt3,
    input  logic                         pt_undo,
    output logic [6:0]                   minutes,
    output logic [5:0]                   seconds,
    output logic [3:0]                   period,
    output logic                         running,
    output logic                         horn,
    output logic                         game_over,
    output logic [SCORE_W*NUM_TEAMS-1:0] scores,
    output logic [7:0]                   anode,
    output logic [6:0]                   seg
);

    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(CLK_HZ - 1);
    localparam logic [TICK_W-1:0]  TICK_ONE    = TICK_W'(1);
    localparam logic [6:0]         MIN_LOAD    = 7'(PERIOD_MIN);
    localparam logic [3:0]         LAST_PERIOD = 4'(NUM_PERIODS);
    localparam logic [SCORE_W-1:0] SCORE_CEIL  = SCORE_W'(SCORE_MAX);

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [31:0]       digits;

    // reset_clock shares the full clock reload with reset and outranks start_pause.
    always_ff @(posedge clock) begin
        if (reset || reset_clock) begin
            state     <= ST_IDLE;
            minutes   <= MIN_LOAD;
            seconds   <= '0;
            period    <= 4'd1;
            tick_cnt  <= '0;
            running   <= 1'b0;
            horn      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            horn <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_pause) begin
                        state    <= ST_RUN;
                        running  <= 1'b1;
                        tick_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (start_pause) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (tick_cnt != TICK_LAST) begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end else begin
                        tick_cnt <= '0;
                        if (seconds != 6'd0) begin
                            seconds <= seconds - 6'd1;
                        end else begin
                            minutes <= minutes - 7'd1;
                            seconds <= 6'd59;
                        end
                        // 00:01 -> 00:00 ends the period; 00:00 is never counted from.
                        if (minutes == 7'd0 && seconds == 6'd1) begin
                            horn    <= 1'b1;
                            running <= 1'b0;
                            if (period == LAST_PERIOD) begin
                                state     <= ST_FINAL;
                                game_over <= 1'b1;
                            end else begin
                                state <= ST_BREAK;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_pause) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (start_pause) begin
                        state    <= ST_RUN;
                        running  <= 1'b1;
                        tick_cnt <= '0;
                        minutes  <= MIN_LOAD;
                        seconds  <= '0;
                        period   <= period + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_TEAMS; i++) begin : g_team
        logic [SCORE_W-1:0] score;

        always_ff @(posedge clock) begin
            if (reset || reset_points) begin
                score <= '0;
            end else if (team_sel == 3'(i)) begin
                if (pt3)          score <= sat_add(score, 2'd3, SCORE_CEIL);
                else if (pt2)     score <= sat_add(score, 2'd2, SCORE_CEIL);
                else if (pt1)     score <= sat_add(score, 2'd1, SCORE_CEIL);
                else if (pt_undo) score <= sat_dec(score);
            end
        end

        assign scores[SCORE_W*i +: SCORE_W] = score;
    end

    // Digit 0 is the minutes tens digit; team0 ones lands on digit 7.
    assign digits = {bcd_ones(scores[6:0]),      bcd_tens(scores[6:0]),
                     bcd_ones(scores[13:7]),     bcd_tens(scores[13:7]),
                     bcd_ones({1'b0, seconds}),  bcd_tens({1'b0, seconds}),
                     bcd_ones(minutes),          bcd_tens(minutes)};

    seg_scan8 #(
        .SCAN_BITS (SCAN_BITS)
    ) u_scan (
        .clock  (clock),
        .reset  (reset),
        .digits (digits),
        .anode  (anode),
        .seg    (seg)
    );

endmodule

// File: tb/tb_game_clock_score_ctrl.sv
// Bench for game_clock_score_ctrl: directed scenarios plus randomized pulses, all checked
// every cycle against a total-seconds behavioural model of clock, scores and display.
module tb_game_clock_score_ctrl;

    localparam int CLK_HZ    = 10;
    localparam int PMIN      = 1;
    localparam int NPER      = 2;
    localparam int NTEAM     = 2;
    localparam int SMAX      = 99;
    localparam int SCAN_BITS = 2;
    localparam int DIG_CYC   = 1 << SCAN_BITS;
    localparam int SCAN_LEN  = 8 * DIG_CYC;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_BREAK = 3;
    localparam int M_FINAL = 4;

    logic        clock;
    logic        reset;
    logic        start_pause;
    logic        reset_clock;
    logic        reset_points;
    logic [2:0]  team_sel;
    logic        pt1;
    logic        pt2;
    logic        pt3;
    logic        pt_undo;
    logic [6:0]  minutes;
    logic [5:0]  seconds;
    logic [3:0]  period;
    logic        running;
    logic        horn;
    logic        game_over;
    logic [13:0] scores;
    logic [7:0]  anode;
    logic [6:0]  seg;

    game_clock_score_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .PERIOD_MIN  (PMIN),
        .NUM_PERIODS (NPER),
        .NUM_TEAMS   (NTEAM),
        .SCORE_MAX   (SMAX),
        .SCAN_BITS   (SCAN_BITS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start_pause  (start_pause),
        .reset_clock  (reset_clock),
        .reset_points (reset_points),
        .team_sel     (team_sel),
        .pt1          (pt1),
        .pt2          (pt2),
        .pt3          (pt3),
        .pt_undo      (pt_undo),
        .minutes      (minutes),
        .seconds      (seconds),
        .period       (period),
        .running      (running),
        .horn         (horn),
        .game_over    (game_over),
        .scores       (scores),
        .anode        (anode),
        .seg          (seg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Active-low {a..g} patterns for decimal digits 0..9.
    int gly [10] = '{'h01, 'h4F, 'h12, 'h06, 'h4C, 'h24, 'h20, 'h0F, 'h00, 'h04};

    int n_cmp = 0;
    int n_bad = 0;

    int m_mode = M_IDLE;
    int m_rem  = PMIN * 60;
    int m_sub  = 0;
    int m_per  = 1;
    int m_sc [NTEAM];
    int m_scan = 0;
    int m_horn = 0;
    int m_seg  = 'h7F;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_score();
        int t;
        int inc;
        if (reset_points) begin
            for (int i = 0; i < NTEAM; i++) m_sc[i] = 0;
        end else if (int'(team_sel) < NTEAM) begin
            t   = int'(team_sel);
            inc = pt3 ? 3 : pt2 ? 2 : pt1 ? 1 : pt_undo ? -1 : 0;
            m_sc[t] = m_sc[t] + inc;
            if (m_sc[t] > SMAX) m_sc[t] = SMAX;
            if (m_sc[t] < 0)    m_sc[t] = 0;
        end
    endtask

    // One clock: model follows the inputs sampled at the edge, then every output is checked.
    task automatic step();
        int d [8];
        d[0] = (m_rem / 60) / 10;
        d[1] = (m_rem / 60) % 10;
        d[2] = (m_rem % 60) / 10;
        d[3] = (m_rem % 60) % 10;
        d[4] = m_sc[1] / 10;
        d[5] = m_sc[1] % 10;
        d[6] = m_sc[0] / 10;
        d[7] = m_sc[0] % 10;
        @(posedge clock);
        m_horn = 0;
        if (reset) begin
            m_mode = M_IDLE; m_rem = PMIN * 60; m_sub = 0; m_per = 1;
            for (int i = 0; i < NTEAM; i++) m_sc[i] = 0;
            m_scan = 0;
            m_seg  = 'h7F;
        end else begin
            if (reset_clock) begin
                m_mode = M_IDLE; m_rem = PMIN * 60; m_sub = 0; m_per = 1;
            end else begin
                case (m_mode)
                    M_IDLE:  if (start_pause) begin m_mode = M_RUN; m_sub = 0; end
                    M_PAUSE: if (start_pause) m_mode = M_RUN;
                    M_BREAK: if (start_pause) begin
                        m_mode = M_RUN; m_sub = 0; m_rem = PMIN * 60; m_per++;
                    end
                    M_RUN: begin
                        if (start_pause) m_mode = M_PAUSE;
                        else begin
                            m_sub++;
                            if (m_sub == CLK_HZ) begin
                                m_sub = 0;
                                m_rem--;
                                if (m_rem == 0) begin
                                    m_horn = 1;
                                    m_mode = (m_per == NPER) ? M_FINAL : M_BREAK;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
            model_score();
            m_scan = (m_scan + 1) % SCAN_LEN;
            m_seg  = gly[d[m_scan / DIG_CYC]];
        end
        #1;
        chk("minutes",   int'(minutes),   m_rem / 60);
        chk("seconds",   int'(seconds),   m_rem % 60);
        chk("period",    int'(period),    m_per);
        chk("running",   int'(running),   (m_mode == M_RUN) ? 1 : 0);
        chk("horn",      int'(horn),      m_horn);
        chk("game_over", int'(game_over), (m_mode == M_FINAL) ? 1 : 0);
        chk("score0",    int'(scores[6:0]),  m_sc[0]);
        chk("score1",    int'(scores[13:7]), m_sc[1]);
        chk("anode",     int'(anode), (~(1 << (m_scan / DIG_CYC))) & 'hFF);
        chk("seg",       int'(seg),   m_seg);
        reset = 1'b0; start_pause = 1'b0; reset_clock = 1'b0; reset_points = 1'b0;
        pt1 = 1'b0; pt2 = 1'b0; pt3 = 1'b0; pt_undo = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int horn_hi;
        for (int i = 0; i < NTEAM; i++) m_sc[i] = 0;
        reset = 1'b1; start_pause = 1'b0; reset_clock = 1'b0; reset_points = 1'b0;
        team_sel = 3'd0; pt1 = 1'b0; pt2 = 1'b0; pt3 = 1'b0; pt_undo = 1'b0;
        step();
        chk("rst_anode", int'(anode), 'hFE);
        chk("rst_min",   int'(minutes), PMIN);
        chk("rst_sec",   int'(seconds), 0);

        // Full first period, horn on the 00:00 load only.
        start_pause = 1'b1; step();
        horn_hi = 0;
        for (int i = 0; i < 601; i++) begin
            step();
            horn_hi += int'(horn);
        end
        chk("t1_mmss", int'(minutes) * 60 + int'(seconds), 0);
        chk("t1_horn_count", horn_hi, 1);
        chk("t1_period", int'(period), 1);
        chk("t1_running", int'(running), 0);

        // Second period to game end; start is then ignored.
        start_pause = 1'b1; step();
        chk("t2_min", int'(minutes), 1);
        chk("t2_period", int'(period), 2);
        idle(602);
        chk("t2_game_over", int'(game_over), 1);
        start_pause = 1'b1; step();
        chk("t2_final_hold", int'(game_over), 1);
        chk("t2_final_run", int'(running), 0);

        // Paused partial second is kept.
        reset_clock = 1'b1; step();
        start_pause = 1'b1; step();
        idle(15);
        start_pause = 1'b1; step();
        idle(49);
        start_pause = 1'b1; step();
        idle(4);
        chk("t3_before_tick", int'(seconds), 59);
        step();
        chk("t3_tick_58", int'(seconds), 58);

        // Saturation at both ends of the score range.
        reset_points = 1'b1; step();
        team_sel = 3'd0;
        for (int i = 0; i < 32; i++) begin pt3 = 1'b1; step(); end
        pt1 = 1'b1; step();
        chk("t4_97", int'(scores[6:0]), 97);
        pt3 = 1'b1; step();
        chk("t4_sat_hi", int'(scores[6:0]), 99);
        pt1 = 1'b1; step();
        chk("t4_sat_hold", int'(scores[6:0]), 99);
        for (int i = 0; i < 100; i++) begin pt_undo = 1'b1; step(); end
        chk("t4_floor", int'(scores[6:0]), 0);

        // Priority among simultaneous pulses and out-of-range team select.
        team_sel = 3'd1; pt1 = 1'b1; pt3 = 1'b1; step();
        chk("t5_prio", int'(scores[13:7]), 3);
        team_sel = 3'd5; pt2 = 1'b1; step();
        chk("t5_sel5_t0", int'(scores[6:0]), 0);
        chk("t5_sel5_t1", int'(scores[13:7]), 3);

        // Reset in the middle of a running period.
        reset_clock = 1'b1; step();
        start_pause = 1'b1; step();
        idle(230);
        chk("t6_at_37", int'(seconds), 37);
        reset = 1'b1; step();
        chk("t6_min", int'(minutes), 1);
        chk("t6_running", int'(running), 0);
        chk("t6_scores", int'(scores), 0);
        chk("t6_anode", int'(anode), 'hFE);

        // Display contents for scores 42/7 at 01:00.
        team_sel = 3'd0;
        for (int i = 0; i < 14; i++) begin pt3 = 1'b1; step(); end
        team_sel = 3'd1;
        pt3 = 1'b1; step();
        pt3 = 1'b1; step();
        pt1 = 1'b1; step();
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_scan / DIG_CYC == 7) chk("t7_digit7", int'(seg), 'h12);
            if (m_scan / DIG_CYC == 6) chk("t7_digit6", int'(seg), 'h4C);
            if (m_scan / DIG_CYC == 5) chk("t7_digit5", int'(seg), 'h0F);
        end

        // Randomized pulses; long stretches of RUN so expiries occur too.
        for (int i = 0; i < 3000; i++) begin
            start_pause  = ($urandom_range(0, 59) == 0);
            reset_clock  = ($urandom_range(0, 499) == 0);
            reset_points = ($urandom_range(0, 299) == 0);
            reset        = ($urandom_range(0, 1499) == 0);
            team_sel     = 3'($urandom_range(0, 7));
            pt1          = ($urandom_range(0, 5) == 0);
            pt2          = ($urandom_range(0, 5) == 0);
            pt3          = ($urandom_range(0, 5) == 0);
            pt_undo      = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
